keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, 1000: CLK cycles each row is driven before its columns are sampled; legal range is at least 2.
REQ-002 Parameter DEBOUNCE_CNT, 20000: consecutive stable cycles required to qualify a press or a release; legal range is at least 1.
REQ-003 Parameter REPEAT_DLY, 500000: held-key cycles before and between auto-repeat events; used only with KEYPAD_REPEAT_EN.
REQ-004 CLK  input  1  is the single clock; all state updates on the rising edge.
REQ-005 RST  input  1  is the reset: synchronous and active-high.
REQ-006 ROW_SEL  output  2  is the binary row index that drives the row decoder.
REQ-007 COL_IN  input  4  carries the active-high column returns; it arrives from a 2-flop synchronizer external to this block.
REQ-008 KEY_CODE  output  4  is the qualified key, {ROW_SEL, col_idx}.
REQ-009 KEY_VALID  output  1  means KEY_CODE holds an unconsumed key.
REQ-010 KEY_ACK  input  1  is asserted by the consumer to accept KEY_CODE.
REQ-011 OVERRUN  output  1  is a one-cycle pulse when a qualified key is dropped.

Function
REQ-012 The FSM SHALL have four states: SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-013 SCAN: a dwell counter counts 0 to SCAN_DIV-1; COL_IN is sampled on the final dwell cycle.
  - If the sample is zero, ROW_SEL increments and wraps from 3 to 0.
  - If the sample is non-zero, ROW_SEL freezes, the sample is latched and the FSM enters DEBOUNCE.
REQ-014 col_idx SHALL be the highest set bit of COL_IN, so the higher column wins within a row; rows are served in scan order.
REQ-015 DEBOUNCE: if COL_IN equals the latched sample for DEBOUNCE_CNT consecutive cycles, the key qualifies and the FSM enters PRESSED.
  - Any mismatch, including zero, returns the FSM to SCAN with ROW_SEL+1 and emits no key.
REQ-016 Emit on qualify: if KEY_VALID=0, or KEY_ACK=1 in the same cycle, KEY_CODE loads and KEY_VALID=1 on the next cycle.
  - Otherwise KEY_CODE is unchanged and OVERRUN pulses for one cycle.
REQ-017 Handshake: KEY_VALID stays high and KEY_CODE stays stable until KEY_ACK is sampled high.
  - KEY_VALID clears on the cycle after the ack, unless a simultaneous emit reloads it.
  - KEY_ACK while KEY_VALID=0 is ignored.
REQ-018 PRESSED: COL_IN=0 moves the FSM to RELEASE; any non-zero value keeps it in PRESSED, with no new emit unless repeat is enabled.
REQ-019 RELEASE: DEBOUNCE_CNT consecutive zero cycles return the FSM to SCAN with ROW_SEL+1 and the dwell counter at 0.
  - Any non-zero cycle returns the FSM to PRESSED.
REQ-020 Counter widths SHALL be $clog2(parameter+1); all counters saturate or clear and never wrap inside a state.
REQ-021 Press-to-KEY_VALID latency SHALL be at most 4*SCAN_DIV + DEBOUNCE_CNT + 2 cycles.

Reset
REQ-022 On RST=1 at a rising edge, all of the following SHALL clear:
  - ROW_SEL=0, KEY_CODE=0, KEY_VALID=0, OVERRUN=0.
  - The FSM returns to SCAN.
  - All counters and the latched sample clear.
REQ-023 RST mid-debounce or mid-handshake SHALL abort the operation silently, with no OVERRUN and no emit.

Configuration
REQ-024 With KEYPAD_REPEAT_EN defined, a key held in PRESSED for REPEAT_DLY cycles SHALL re-emit the same code under REQ-016.
  - Re-emits then repeat every REPEAT_DLY cycles.
  - The repeat counter clears on entry to RELEASE.
REQ-025 With KEYPAD_REPEAT_EN undefined, exactly one emit SHALL occur per press, and no repeat counter is synthesized.

Structure
REQ-026 Package keypad_pkg SHALL hold:
  - the FSM state typedef;
  - the constants NUM_ROWS=4, NUM_COLS=4 and KEY_W=4.
REQ-027 The stability counter SHALL be a sub-module, keypad_stable_cnt, shared by DEBOUNCE and RELEASE.
  - Inputs: match and clear.
  - Output: done at DEBOUNCE_CNT.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_DLY=32)
REQ-028 Test 1, idle:
  - Stimulus: COL_IN=0 for 64 cycles.
  - Response: ROW_SEL sequence 0,1,2,3,0 changing every 4 cycles; KEY_VALID=0.
REQ-029 Test 2, single press:
  - Stimulus: hold COL_IN=4'b0100 only while ROW_SEL=2, then ack.
  - Response: KEY_CODE=4'b1010 and KEY_VALID=1, held until KEY_ACK; cleared on the cycle after the ack.
REQ-030 Test 3, bounce:
  - Stimulus: COL_IN drops to 0 on cycle 5 of the debounce.
  - Response: no emit; ROW_SEL advances.
  - Stimulus: a second stable press on the same key.
  - Response: one emit.
REQ-031 Test 4, overrun:
  - Stimulus: two presses, with no ack between them.
  - Response: first code retained and OVERRUN pulses once.
  - Stimulus: repeat with KEY_ACK asserted on the second qualify cycle.
  - Response: the new code loads and KEY_VALID stays 1.
REQ-032 Test 5, multi-key:
  - Stimulus: COL_IN=4'b1001 on row 1.
  - Response: KEY_CODE=4'b0111.
  - Stimulus: RST asserted during DEBOUNCE.
  - Response: all outputs 0 on the next cycle and ROW_SEL=0.
REQ-033 Test 6, repeat:
  - Stimulus: hold a key for 100 cycles, acking each emit immediately.
  - Response with KEYPAD_REPEAT_EN: emits at qualify, qualify+32 and qualify+64.
  - Response without KEYPAD_REPEAT_EN: exactly one emit.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned KEY_W    = 4;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StPressed,
    StRelease
  } state_e;

  // Highest set column wins when several keys in one row are down.
  function automatic logic [1:0] f_col_idx(input logic [NUM_COLS-1:0] cols);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (cols[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_stable_cnt.sv
// Consecutive-match counter used to qualify both presses and releases.
module keypad_stable_cnt #(
  parameter int unsigned DEBOUNCE_CNT = 20000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_match,
  input  logic i_clear,
  output logic o_done
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CNT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || !i_match) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_FULL) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Done on the DEBOUNCE_CNT-th consecutive matching cycle itself.
  assign o_done = i_match && !i_clear && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad controller with debounce and valid/ack key output.
// Optional auto-repeat of a held key: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20000,
  parameter int unsigned REPEAT_DLY   = 500000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic [1:0]          o_row_sel,
  input  logic [NUM_COLS-1:0] i_col_in,
  output logic [KEY_W-1:0]    o_key_code,
  output logic                o_key_valid,
  input  logic                i_key_ack,
  output logic                o_overrun
);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_DLY < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter value");
  end

  localparam int unsigned DW = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  state_e              r_state;
  logic [1:0]          r_row;
  logic [DW-1:0]       r_dwell;
  logic [NUM_COLS-1:0] r_sample;
  logic [KEY_W-1:0]    r_key_code;
  logic                r_key_valid;
  logic                r_overrun;

  logic w_match;
  logic w_clear;
  logic w_done;
  logic w_qualify;
  logic w_repeat;
  logic w_emit;

  always_comb begin
    w_match   = (r_state == StRelease) ? (i_col_in == '0) : (i_col_in == r_sample);
    w_clear   = (r_state == StScan) || (r_state == StPressed);
    w_qualify = (r_state == StDebounce) && w_done;
    w_emit    = w_qualify || w_repeat;
  end

  keypad_stable_cnt #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_stable_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_match(w_match),
    .i_clear(w_clear),
    .o_done (w_done)
  );

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_DLY + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DLY - 1);

  logic [RW-1:0] r_rep_cnt;

  // Runs only while a key is held in PRESSED; restarts after every repeat.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != StPressed) || (i_col_in == '0) || w_repeat) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end

  assign w_repeat = (r_state == StPressed) && (i_col_in != '0) && (r_rep_cnt == REP_LAST);
`else
  assign w_repeat = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StScan;
      r_row       <= '0;
      r_dwell     <= '0;
      r_sample    <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_emit) begin
        if (!r_key_valid || i_key_ack) begin
          r_key_code  <= {r_row, f_col_idx(r_sample)};
          r_key_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (i_key_ack) begin
        r_key_valid <= 1'b0;
      end

      unique case (r_state)
        StScan: begin
          if (r_dwell == DWELL_LAST) begin
            r_dwell <= '0;
            if (i_col_in == '0) begin
              r_row <= r_row + 1'b1;
            end else begin
              r_sample <= i_col_in;
              r_state  <= StDebounce;
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        StDebounce: begin
          if (!w_match) begin
            r_state <= StScan;
            r_row   <= r_row + 1'b1;
            r_dwell <= '0;
          end else if (w_done) begin
            r_state <= StPressed;
          end
        end
        StPressed: begin
          if (i_col_in == '0) r_state <= StRelease;
        end
        StRelease: begin
          if (!w_match) begin
            r_state <= StPressed;
          end else if (w_done) begin
            r_state <= StScan;
            r_row   <= r_row + 1'b1;
            r_dwell <= '0;
          end
        end
        default: r_state <= StScan;
      endcase
    end
  end

  assign o_row_sel   = r_row;
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_overrun   = r_overrun;

endmodule
